// File: rtl/tetris_input.sv
// Button front end for the Tetris core: synchronise, debounce, and turn presses into move pulses.
// Define TETRIS_INPUT_AUTO_REPEAT_EN to give left/right a held-key auto-repeat.
module tetris_input #(
  parameter int DB_CYCLES  = 4,
  parameter int RPT_DELAY  = 16,
  parameter int RPT_PERIOD = 4
) (
  input  logic gm_clk,
  input  logic gm_rst,
  input  logic btn_down_raw,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  input  logic btn_rott_raw,
  output logic down,
  output logic left,
  output logic right,
  output logic rott
);

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  if (DB_CYCLES < 1 || DB_CYCLES > 65535 || RPT_PERIOD < 2 || RPT_PERIOD > 65535 ||
      RPT_DELAY <= RPT_PERIOD || RPT_DELAY > 65536) begin : g_bad_param
    $error("tetris_input: illegal parameter set");
  end

  // Bit order everywhere: 0 = down, 1 = left, 2 = right, 3 = rotate.
  logic [3:0]  raw;
  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic [3:0]  stable;
  logic [15:0] db_cnt [4];
  logic        rott_d;

  assign raw = {btn_rott_raw, btn_right_raw, btn_left_raw, btn_down_raw};

  always_ff @(posedge gm_clk) begin
    if (gm_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // stable only flips after the synchronised level has disagreed for DB_CYCLES edges in a row.
  always_ff @(posedge gm_clk) begin
    if (gm_rst) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge gm_clk) begin
    if (gm_rst) begin
      down   <= 1'b0;
      rott   <= 1'b0;
      rott_d <= 1'b0;
    end else begin
      down   <= stable[0];
      rott_d <= stable[3];
      rott   <= stable[3] & ~rott_d;
    end
  end

`ifdef TETRIS_INPUT_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  localparam logic [15:0] DLY_LAST = 16'(RPT_DELAY - 1);
  localparam logic [15:0] PER_LAST = 16'(RPT_PERIOD - 1);

  // Index 0 = left, 1 = right.
  rpt_state_t  state     [2];
  rpt_state_t  state_nxt [2];
  logic [15:0] rpt_cnt   [2];
  logic [15:0] cnt_nxt   [2];
  logic [1:0]  pulse_nxt;
  logic [1:0]  held;
  logic        both_held;

  assign held      = stable[2:1];
  assign both_held = stable[1] & stable[2];

  always_ff @(posedge gm_clk) begin
    if (gm_rst) begin
      for (int i = 0; i < 2; i++) begin
        state[i]   <= IDLE;
        rpt_cnt[i] <= '0;
      end
      left  <= 1'b0;
      right <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i]   <= state_nxt[i];
        rpt_cnt[i] <= cnt_nxt[i];
      end
      left  <= pulse_nxt[0];
      right <= pulse_nxt[1];
    end
  end

  // Holding left and right together freezes both repeat timers; fresh presses still pulse.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = rpt_cnt[i];
      pulse_nxt[i] = 1'b0;
      case (state[i])
        IDLE: begin
          if (held[i]) begin
            state_nxt[i] = DELAY;
            cnt_nxt[i]   = '0;
            pulse_nxt[i] = 1'b1;
          end
        end
        DELAY, REPEAT: begin
          if (!held[i]) begin
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end else if (!both_held) begin
            if (rpt_cnt[i] == ((state[i] == DELAY) ? DLY_LAST : PER_LAST)) begin
              state_nxt[i] = REPEAT;
              cnt_nxt[i]   = '0;
              pulse_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i] = rpt_cnt[i] + 16'd1;
            end
          end
        end
        default: begin
          state_nxt[i] = IDLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end
`else
  logic [1:0] move_d;

  always_ff @(posedge gm_clk) begin
    if (gm_rst) begin
      left   <= 1'b0;
      right  <= 1'b0;
      move_d <= '0;
    end else begin
      move_d <= stable[2:1];
      left   <= stable[1] & ~move_d[0];
      right  <= stable[2] & ~move_d[1];
    end
  end
`endif

endmodule

// File: tb/tb_tetris_input.sv
// Directed bench for tetris_input at default parameters; follows TETRIS_INPUT_AUTO_REPEAT_EN if defined.
module tb_tetris_input;

  logic gm_clk;
  logic gm_rst;
  logic btn_down_raw;
  logic btn_left_raw;
  logic btn_right_raw;
  logic btn_rott_raw;
  logic down;
  logic left;
  logic right;
  logic rott;

  int compared   = 0;
  int mismatched = 0;

`ifdef TETRIS_INPUT_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  tetris_input dut (
    .gm_clk       (gm_clk),
    .gm_rst       (gm_rst),
    .btn_down_raw (btn_down_raw),
    .btn_left_raw (btn_left_raw),
    .btn_right_raw(btn_right_raw),
    .btn_rott_raw (btn_rott_raw),
    .down         (down),
    .left         (left),
    .right        (right),
    .rott         (rott)
  );

  initial gm_clk = 1'b0;
  always #5 gm_clk = ~gm_clk;

  task automatic checkOutput(input string tag, input logic got, input logic exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic d, input logic l, input logic r, input logic t);
    btn_down_raw  = d;
    btn_left_raw  = l;
    btn_right_raw = r;
    btn_rott_raw  = t;
  endtask

  // After step() we sit 1 time unit past a rising edge; that edge samples whatever was applied before it.
  task automatic step();
    @(posedge gm_clk);
    #1;
  endtask

  task automatic settle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
  endtask

  initial begin
    logic exp;
    gm_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    checkOutput("reset_down",  down,  1'b0);
    checkOutput("reset_left",  left,  1'b0);
    checkOutput("reset_right", right, 1'b0);
    checkOutput("reset_rott",  rott,  1'b0);
    gm_rst = 1'b0;
    repeat (3) step();

    $display("[TB] left held 40 cycles");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 40; e++) begin
      step();
      if (e == 39) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      exp = (e == 6) || (AR && e >= 22 && e <= 38 && ((e - 22) % 4) == 0);
      checkOutput($sformatf("hold_left@%0d", e), left, exp);
    end
    settle();
    checkOutput("hold_left_idle", left, 1'b0);

    $display("[TB] rotate bounce then hold");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 4; e <= 30; e++) begin
      step();
      checkOutput($sformatf("bounce_rott@%0d", e), rott, e == 10);
    end
    settle();

    $display("[TB] rotate 3-cycle glitch");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 0; e <= 14; e++) begin
      step();
      if (e == 2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("glitch_rott@%0d", e), rott, 1'b0);
    end
    settle();

    $display("[TB] down held 10 cycles");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e <= 20; e++) begin
      step();
      if (e == 9) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("down_level@%0d", e), down, e >= 6 && e <= 15);
    end
    settle();

    $display("[TB] left held, right joins then leaves");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 66; e++) begin
      step();
      if (e == 26) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      if (e == 46) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      exp = (e == 6) ||
            (AR && (e == 22 || e == 26 || e == 30 || (e >= 54 && ((e - 54) % 4) == 0)));
      checkOutput($sformatf("both_left@%0d", e), left, exp);
      checkOutput($sformatf("both_right@%0d", e), right, e == 33);
    end
    settle();

    $display("[TB] reset pulse while left repeating");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 40; e++) begin
      step();
      if (e == 23) gm_rst = 1'b1;
      if (e == 24) gm_rst = 1'b0;
      exp = (e == 6) || (AR && e == 22) || (e == 31);
      checkOutput($sformatf("rst_left@%0d", e), left, exp);
      if (e == 24 || e == 25) begin
        checkOutput($sformatf("rst_down@%0d", e),  down,  1'b0);
        checkOutput($sformatf("rst_right@%0d", e), right, 1'b0);
        checkOutput($sformatf("rst_rott@%0d", e),  rott,  1'b0);
      end
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
